fifo_rd_arbiter: RTL and testbench

- Read-side scheduler for the asynchronous FIFO. It shares the single FIFO read port among NREQ consumers in the read clock domain.
- Arbitration is round-robin. A winner holds the port for a bounded burst of up to MAXBURST words.
- The block drives the read-pointer increment (rinc), captures FIFO read data and returns it to the granted consumer with a per-consumer valid strobe.
- Sits between the read-pointer/memory pair and the downstream consumers.

---
 rtl/fifo_rd_arbiter_if.sv | 33 +++
 rtl/fifo_rd_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bus between the FIFO read port, the arbiter and its NREQ consumers.
// The arbiter uses the master modport. The environment (FIFO plus consumers) uses the slave modport.
interface fifo_rd_arbiter_if #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
);
  localparam int CW = $clog2(MAXBURST + 1);

  // Handshake: req[i] is a level request that stays high while consumer i wants words.
  // rinc pops the word on rdata at the rising edge and is never high while rempty is high.
  // out_valid is a one-cycle strobe that has no backpressure.
  // A consumer must take out_data in the cycle where its out_valid bit is set.
  logic                rempty;
  logic [DATASIZE-1:0] rdata;
  logic [NREQ-1:0]     req;
  logic                rinc;
  logic [NREQ-1:0]     gnt;
  logic [DATASIZE-1:0] out_data;
  logic [NREQ-1:0]     out_valid;
  logic [CW-1:0]       burst_cnt;
  logic                in_burst;

  modport master (
    input  rempty, rdata, req,
    output rinc, gnt, out_data, out_valid, burst_cnt, in_burst
  );

  modport slave (
    output rempty, rdata, req,
    input  rinc, gnt, out_data, out_valid, burst_cnt, in_burst
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler that shares one FIFO read port among NREQ consumers.
// Each grant lasts for a bounded burst of up to MAXBURST words.
module fifo_rd_arbiter #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic              rclk,
  input  logic              r_rst_n,
  fifo_rd_arbiter_if.master bus
);
  localparam int CW = $clog2(MAXBURST + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       last, last_nx;
  logic [IW-1:0]       winner, idx;
  logic                found;
  logic [NREQ-1:0]     gnt_q, gnt_nx;
  logic [NREQ-1:0]     valid_q, valid_nx;
  logic [DATASIZE-1:0] data_q, data_nx;
  logic [CW-1:0]       cnt_q, cnt_nx;
  logic                rinc;

  // Search starts one past the previous winner and wraps, so the last owner gets the lowest priority.
  always_comb begin : pick
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // While in BURST, 'last' equals the owner, because it is updated only when a grant is made.
  always_comb begin : fsm_next
    state_nx = state;
    last_nx  = last;
    gnt_nx   = gnt_q;
    valid_nx = '0;
    data_nx  = data_q;
    cnt_nx   = cnt_q;
    rinc     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.rempty && found) begin
          state_nx       = BURST;
          gnt_nx         = '0;
          gnt_nx[winner] = 1'b1;
          last_nx        = winner;
          cnt_nx         = '0;
        end
      end
      BURST: begin
        rinc = bus.req[last] & ~bus.rempty;
        if (rinc) begin
          data_nx  = bus.rdata;
          valid_nx = gnt_q;
          cnt_nx   = cnt_q + 1'b1;
        end
        // A cycle without rinc means the owner withdrew or the FIFO drained. Either way, release the grant.
        if (!rinc || cnt_q == CW'(MAXBURST - 1)) begin
          state_nx = IDLE;
          gnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state   <= IDLE;
      last    <= IW'(NREQ - 1);
      gnt_q   <= '0;
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      gnt_q   <= gnt_nx;
      valid_q <= valid_nx;
      data_q  <= data_nx;
      cnt_q   <= cnt_nx;
    end
  end

  assign bus.rinc      = rinc;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.burst_cnt = cnt_q;
  assign bus.in_burst  = (state == BURST);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter. It contains a queue-based FIFO model and a scoreboard of popped words.
// The scoreboard is keyed by the expected consumer.
module tb_fifo_rd_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.DATASIZE(DW), .NREQ(N), .MAXBURST(MB)) bus();

  fifo_rd_arbiter #(.DATASIZE(DW), .NREQ(N), .MAXBURST(MB)) dut (
    .rclk    (clk),
    .r_rst_n (rst_n),
    .bus     (bus)
  );

  logic [DW-1:0]   fifo_q[$];
  logic [N+DW-1:0] exp_q[$];
  int              seq_q[$];
  int              lens_q[$];
  int              gaps_q[$];
  int              cur_owner, cur_len, idle_cnt;
  logic            had_grant;
  logic [N-1:0]    prev_gnt;
  int              n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic fifo_refresh();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom_range(0, 255)));
    fifo_refresh();
  endtask

  task automatic flush();
    fifo_q.delete();
    fifo_refresh();
  endtask

  task automatic clear_track();
    lens_q.delete();
    gaps_q.delete();
    seq_q.delete();
    had_grant = 1'b0;
  endtask

  // One clock cycle. rinc is sampled at the negedge, and outputs are checked 1 time unit after the posedge.
  task automatic tick();
    logic            pop;
    logic [N+DW-1:0] e;
    logic [N-1:0]    oh;
    @(negedge clk);
    pop = bus.rinc;
    check_eq("no_underflow", 32'(bus.rinc & bus.rempty), 32'd0);
    if (pop) begin
      oh = N'(1) << cur_owner;
      exp_q.push_back({oh, fifo_q[0]});
      cur_len++;
    end
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("out_valid", 32'(bus.out_valid), 32'(e[N+DW-1:DW]));
      check_eq("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
    end else begin
      check_eq("out_valid_quiet", 32'(bus.out_valid), 32'd0);
    end
    check_eq("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    if (prev_gnt != '0 && bus.gnt == '0) begin
      lens_q.push_back(cur_len);
      idle_cnt = 0;
    end
    if (prev_gnt == '0 && bus.gnt != '0) begin
      if (seq_q.size() > 0) begin
        cur_owner = seq_q.pop_front();
        check_eq("gnt_order", 32'(bus.gnt), 32'(1) << cur_owner);
      end else begin
        check_eq("unexpected_gnt", 32'(bus.gnt), 32'd0);
      end
      if (had_grant) gaps_q.push_back(idle_cnt);
      had_grant = 1'b1;
      cur_len   = 0;
    end
    if (bus.gnt == '0) idle_cnt++;
    check_eq("burst_cnt", 32'(bus.burst_cnt), 32'(cur_len));
    prev_gnt = bus.gnt;
  endtask

  task automatic run_grants(input int target, input int budget);
    int c = 0;
    while (lens_q.size() < target && c < budget) begin
      tick();
      c++;
    end
    check_eq("grants_done", 32'(lens_q.size()), 32'(target));
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (!(bus.gnt != '0 && cur_len >= n) && c < budget) begin
      tick();
      c++;
    end
    check_eq("pops_reached", 32'(cur_len), 32'(n));
  endtask

  task automatic check_lens(input string tag, input int exp_lens[$]);
    check_eq({tag, "_count"}, 32'(lens_q.size()), 32'(exp_lens.size()));
    for (int i = 0; i < exp_lens.size() && i < lens_q.size(); i++)
      check_eq(tag, 32'(lens_q[i]), 32'(exp_lens[i]));
  endtask

  task automatic check_gaps(input string tag, input int n);
    check_eq({tag, "_count"}, 32'(gaps_q.size()), 32'(n));
    for (int i = 0; i < gaps_q.size(); i++) check_eq(tag, 32'(gaps_q[i]), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cur_owner = 0;
    cur_len   = 0;
    idle_cnt  = 0;
    prev_gnt  = '0;
    had_grant = 1'b0;
    rst_n     = 1'b0;
    bus.req   = '0;
    flush();

    // reset state
    #1;
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_burst_cnt", 32'(bus.burst_cnt), 32'd0);
    check_eq("rst_rinc", 32'(bus.rinc), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // all requesting, FIFO kept full: order 0,1,2,3,0 with 4 pops each
    clear_track();
    fill(40);
    seq_q = {0, 1, 2, 3, 0};
    bus.req = 4'b1111;
    run_grants(5, 60);
    bus.req = '0;
    check_lens("rr_len", {4, 4, 4, 4, 4});
    check_gaps("rr_gap", 4);
    repeat (2) tick();

    // single requester, ten words: bursts of 4,4,2, and the last burst ends on empty
    flush();
    clear_track();
    fill(10);
    seq_q = {0, 0, 0};
    bus.req = 4'b0001;
    run_grants(3, 40);
    check_lens("solo_len", {4, 4, 2});
    check_gaps("solo_gap", 2);
    repeat (3) tick();
    check_eq("solo_drained", 32'(fifo_q.size()), 32'd0);
    bus.req = '0;
    tick();

    // owner withdraws after two pops, and the grant then moves to requester 2
    clear_track();
    fill(8);
    seq_q = {1, 2};
    bus.req = 4'b0010;
    wait_pops(2, 20);
    bus.req = 4'b0100;
    tick();
    check_eq("wd_released", 32'(bus.gnt), 32'd0);
    check_eq("wd_idle", 32'(bus.in_burst), 32'd0);
    check_eq("wd_cnt", 32'(bus.burst_cnt), 32'd2);
    run_grants(2, 30);
    check_lens("wd_len", {2, 4});
    bus.req = '0;
    repeat (2) tick();

    // one word in the FIFO for requester 3
    flush();
    clear_track();
    fill(1);
    seq_q = {3};
    bus.req = 4'b1000;
    run_grants(1, 10);
    check_lens("one_len", {1});
    repeat (3) tick();
    bus.req = '0;
    tick();

    // reset mid-burst after two pops
    clear_track();
    fill(10);
    seq_q = {0};
    bus.req = 4'b0001;
    wait_pops(2, 20);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_burst_cnt", 32'(bus.burst_cnt), 32'd0);
    check_eq("mid_rst_rinc", 32'(bus.rinc), 32'd0);
    exp_q.delete();
    clear_track();
    prev_gnt = '0;
    cur_len  = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    seq_q = {0, 1};
    bus.req = 4'b0011;
    run_grants(2, 30);
    check_lens("post_rst_len", {4, 4});
    bus.req = '0;
    tick();

    // wrap: requester 3 wins first, then 0 (wrap), then 3 again
    flush();
    clear_track();
    fill(20);
    seq_q = {3, 0, 3};
    bus.req = 4'b1001;
    run_grants(3, 50);
    check_lens("wrap_len", {4, 4, 4});
    bus.req = '0;
    repeat (2) tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
